// File: rtl/cpu_decode_pkg.sv
// Shared opcode space, condition codes and decoded-bundle type for the decode queue.
// Also hosts the ARM condition-evaluation helper used when DECODE_COND_EVAL_EN is defined.
package cpu_decode_pkg;

  localparam int OP_WIDTH = 5;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND  = 5'd0,  OP_EOR = 5'd1,  OP_SUB = 5'd2,  OP_RSB = 5'd3,
    OP_ADD  = 5'd4,  OP_ADC = 5'd5,  OP_SBC = 5'd6,  OP_RSC = 5'd7,
    OP_TST  = 5'd8,  OP_TEQ = 5'd9,  OP_CMP = 5'd10, OP_CMN = 5'd11,
    OP_ORR  = 5'd12, OP_MOV = 5'd13, OP_BIC = 5'd14, OP_MVN = 5'd15,
    OP_LDR  = 5'd16, OP_STR = 5'd17, OP_LDRB = 5'd18, OP_STRB = 5'd19,
    OP_B    = 5'd20, OP_BL  = 5'd21, OP_INV  = 5'd31
  } opcode_t;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  typedef struct packed {
    opcode_t     opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] imm;
    logic [23:0] branch_offset;
    logic [4:0]  shift_amt;
    logic [1:0]  shift_type;
    logic        imm_flag;
    logic [3:0]  cond;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        mem_byte;
    logic        branch;
    logic        link;
    logic        flags_we;
    logic        undef;
  } decode_t;

  // nzcv bit order: [3]=N [2]=Z [1]=C [0]=V
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_decode_comb.sv
// Purely combinational decode of one 32-bit ARM-format word into a decode_t bundle.
module arm_decode_comb
  import cpu_decode_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     bundle
);

  decode_t d;
  logic    undef;

  always_comb begin
    d      = '0;
    undef  = 1'b0;
    d.cond = instr[31:28];
    if (instr[31:28] == COND_NV) begin
      undef = 1'b1;
    end else if (instr[27:26] == 2'b00) begin
      d.opcode   = opcode_t'({1'b0, instr[24:21]});
      d.imm_flag = instr[25];
      d.rd       = instr[15:12];
      d.rs1      = instr[19:16];
      if (instr[25]) begin
        d.imm = instr[11:0];
      end else begin
        d.rs2        = instr[3:0];
        d.shift_amt  = instr[11:7];
        d.shift_type = instr[6:5];
      end
      // TST/TEQ/CMP/CMN only ever write flags
      if (instr[24:23] == 2'b10) begin
        d.reg_we   = 1'b0;
        d.flags_we = 1'b1;
      end else begin
        d.reg_we   = 1'b1;
        d.flags_we = instr[20];
      end
    end else if (instr[27:26] == 2'b01) begin
      if (instr[25]) begin
        undef = 1'b1;
      end else begin
        d.imm      = instr[11:0];
        d.imm_flag = 1'b1;
        d.rs1      = instr[19:16];
        d.rd       = instr[15:12];
        d.mem_byte = instr[22];
        if (instr[20]) begin
          d.opcode = instr[22] ? OP_LDRB : OP_LDR;
          d.mem_re = 1'b1;
          d.reg_we = 1'b1;
        end else begin
          d.opcode = instr[22] ? OP_STRB : OP_STR;
          d.mem_we = 1'b1;
          d.rs2    = instr[15:12];
        end
      end
    end else if (instr[27:25] == 3'b101) begin
      d.branch        = 1'b1;
      d.branch_offset = instr[23:0];
      if (instr[24]) begin
        d.opcode = OP_BL;
        d.link   = 1'b1;
        d.reg_we = 1'b1;
        d.rd     = 4'd14;
      end else begin
        d.opcode = OP_B;
      end
    end else begin
      undef = 1'b1;
    end

    if (undef) begin
      d        = '0;
      d.cond   = instr[31:28];
      d.opcode = OP_INV;
      d.undef  = 1'b1;
    end
  end

  assign bundle = d;

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: DEPTH-entry instruction FIFO feeding a registered decoded-bundle output.
// Optional macro DECODE_COND_EVAL_EN gates the bundle's enables with NZCV condition evaluation.
module decode_queue
  import cpu_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int OP_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [OP_W-1:0]          out_opcode,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_rs1,
  output logic [3:0]               out_rs2,
  output logic [11:0]              out_imm,
  output logic [23:0]              out_branch_offset,
  output logic [4:0]               out_shift_amt,
  output logic [1:0]               out_shift_type,
  output logic                     out_imm_flag,
  output logic [3:0]               out_cond,
  output logic                     out_reg_we,
  output logic                     out_mem_re,
  output logic                     out_mem_we,
  output logic                     out_mem_byte,
  output logic                     out_branch,
  output logic                     out_link,
  output logic                     out_flags_we,
  output logic                     out_undef,
  output logic                     out_cond_pass,
  input  logic [3:0]               flags_nzcv,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic            push, pop;
  decode_t         head_dec, out_q;
  logic [PC_W-1:0] out_pc_q;
  logic            out_valid_q;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid_q || out_ready);

  arm_decode_comb u_dec (
    .instr  (mem_instr[rd_ptr]),
    .bundle (head_dec)
  );

  // Storage needs no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_q.opcode <= OP_INV;
      out_pc_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_q       <= head_dec;
      out_pc_q    <= mem_pc[rd_ptr];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_COND_EVAL_EN
  assign out_cond_pass = cond_pass(out_q.cond, flags_nzcv);
`else
  logic unused_flags;
  assign unused_flags  = ^flags_nzcv;
  assign out_cond_pass = 1'b1;
`endif

  assign out_valid         = out_valid_q;
  assign out_pc            = out_pc_q;
  assign out_opcode        = OP_W'(out_q.opcode);
  assign out_rd            = out_q.rd;
  assign out_rs1           = out_q.rs1;
  assign out_rs2           = out_q.rs2;
  assign out_imm           = out_q.imm;
  assign out_branch_offset = out_q.branch_offset;
  assign out_shift_amt     = out_q.shift_amt;
  assign out_shift_type    = out_q.shift_type;
  assign out_imm_flag      = out_q.imm_flag;
  assign out_cond          = out_q.cond;
  assign out_mem_byte      = out_q.mem_byte;
  assign out_undef         = out_q.undef;
  // A failed condition still delivers the bundle, just with its side effects suppressed.
  assign out_reg_we        = out_q.reg_we   && out_cond_pass;
  assign out_mem_re        = out_q.mem_re   && out_cond_pass;
  assign out_mem_we        = out_q.mem_we   && out_cond_pass;
  assign out_branch        = out_q.branch   && out_cond_pass;
  assign out_link          = out_q.link     && out_cond_pass;
  assign out_flags_we      = out_q.flags_we && out_cond_pass;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, parametrised decode stage between fetch and execute.
- Accepts 32-bit ARM-format instructions with their PC through a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Decodes the FIFO head and presents the decoded bundle in a registered output stage, also valid/ready.
- Adds over a purely combinational decoder: buffering, back-pressure, flush, an explicit undefined-instruction flag, and optional condition evaluation.

Parameters:
DEPTH, 4, FIFO entries (power of two, at least 2)
PC_W, 32, width of PC carried with each instruction
OP_W, 5, decoded opcode width (must match package)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous; discard all queued and output contents
in_valid  in  1  fetch presents instruction
in_ready  out  1  queue can accept; equals (count < DEPTH)
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
out_pc  out  PC_W  PC of bundle
out_opcode  out  OP_W  package opcode
out_rd, out_rs1, out_rs2  out  4 each  register indices
out_imm  out  12  immediate/offset
out_branch_offset  out  24  branch word offset
out_shift_amt  out  5  shift amount
out_shift_type  out  2  shift type
out_imm_flag  out  1  operand 2 is immediate
out_cond  out  4  condition field
out_reg_we, out_mem_re, out_mem_we, out_mem_byte, out_branch, out_link, out_flags_we  out  1 each  control enables
out_undef  out  1  undefined instruction
out_cond_pass  out  1  condition satisfied (see Optional Feature)
flags_nzcv  in  4  current NZCV (used only with feature)
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, count=0, out_valid=0, every out_* field 0, out_opcode=OP_INV.
- Push: in_valid && in_ready. Pop: FIFO non-empty && (!out_valid || out_ready); the popped head is decoded and registered into the output stage in the same edge.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 instruction/cycle sustained. No bypass of an empty FIFO.
- Stall: out_valid && !out_ready holds all out_* stable.
- Simultaneous push and pop: count unchanged. Push while full is impossible (in_ready=0). Pointers wrap modulo DEPTH.
- flush: at the edge, count=0, out_valid=0, pointers reset. Flush overrides any push or pop in the same cycle, and that push is dropped. Resumes normally the next cycle.
- Decode rules; defaults 0, cond=instr[31:28]:
  - cond==1111: undefined.
  - [27:26]=00, data processing:
    - opcode = package code indexed by [24:21]; imm_flag=[25]; rd=[15:12]; rs1=[19:16].
    - If I: imm=[11:0]. Else: rs2=[3:0], shift_amt=[11:7], shift_type=[6:5].
    - Compare class ([24:23]=10): reg_we=0, flags_we=1.
    - Otherwise: reg_we=1, flags_we=[20].
  - [27:26]=01, load/store:
    - [25]=1 is undefined.
    - Otherwise: imm=[11:0], imm_flag=1, rs1=[19:16], rd=[15:12], mem_byte=[22].
    - L=[20]=1: LDR/LDRB, mem_re=1, reg_we=1.
    - L=0: STR/STRB, mem_we=1, rs2=[15:12].
  - [27:25]=101, branch: branch=1, offset=[23:0]. If [24]: BL, link=1, reg_we=1, rd=14. Else: B. The condition travels in out_cond only.
  - All other encodings: undefined.
- Undefined handling: opcode=OP_INV, out_undef=1, all enables 0, still delivered in order.

Optional Feature:
- Macro: DECODE_COND_EVAL_EN.
- Enabled: out_cond_pass is a combinational function of out_cond and flags_nzcv, using standard ARM EQ..AL semantics; 1111 gives 0. When out_cond_pass=0, out_reg_we, out_mem_re, out_mem_we, out_branch, out_link and out_flags_we are forced to 0. The bundle is still delivered.
- Disabled: out_cond_pass tied to 1, flags_nzcv ignored, enables ungated.

Decomposition:
- Package cpu_decode_pkg:
  - OP_AND..OP_MVN = 0..15, matching [24:21]; TEQ keeps its own code 9.
  - OP_LDR=16, OP_STR=17, OP_LDRB=18, OP_STRB=19, OP_B=20, OP_BL=21, OP_INV=31.
  - Condition code constants and a decoded-bundle struct.
- Sub-module arm_decode_comb: pure combinational decode of one word to the bundle. It is instantiated on the FIFO head.

Test Plan:
- Reset then push E2821005 (ADD r1,r2,#5) at pc 0x100 -> out_valid 2 cycles later, opcode=4, rd=1, rs1=2, imm=5, imm_flag=1, reg_we=1, flags_we=0.
- Push E1530004 (CMP r3,r4) -> opcode=10, rs1=3, rs2=4, reg_we=0, flags_we=1, imm_flag=0.
- Push E5D10004 (LDRB r0,[r1,#4]) then EB000010 (BL):
  - LDRB: opcode=18, mem_re=1, mem_byte=1, imm=4.
  - BL: opcode=21, link=1, rd=14, offset=0x10.
- Hold out_ready=0 and push 5 words with DEPTH=4 -> in_ready drops at count=4, output stable. Release -> 5 bundles in order, no loss or duplicate.
- Assert flush while full and pushing -> next cycle count=0, out_valid=0, the pushed word never appears. Also push F0000000 -> out_undef=1, opcode=31, all enables 0.
- With DECODE_COND_EVAL_EN: push 0A000002 (BEQ) with flags_nzcv=0000 -> out_cond_pass=0, out_branch=0. Same with Z=1 -> out_cond_pass=1, out_branch=1.
